// File: rtl/crc_pkg.sv
// Shared types and USB CRC constants for the streaming CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } crc_state_t;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
   localparam logic [4:0]  CRC5_POLY      = 5'h05;
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;

endpackage

// File: rtl/crc_stream_if.sv
// Beat-level handshakes of the CRC engine: data in, appended CRC beats out.
interface crc_stream_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/crc_step_n.sv
// Combinational DW-bit CRC update, equivalent to DW serial steps with bit 0 first.
module crc_step_n #(
   parameter int               NBITS = 16,
   parameter int               DW    = 8,
   parameter logic [NBITS-1:0] POLY  = 16'h8005
) (
   input  logic [NBITS-1:0] r,
   input  logic [DW-1:0]    d,
   output logic [NBITS-1:0] r_next
);

   logic [NBITS-1:0] acc;
   logic             flip;

   always_comb begin
      acc  = r;
      flip = 1'b0;
      for (int i = 0; i < DW; i++) begin
         flip = d[i] ^ acc[NBITS-1];
         acc  = {acc[NBITS-2:0], 1'b0} ^ (flip ? POLY : '0);
      end
      r_next = acc;
   end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: checks a frame against the residual, or appends the
// complemented CRC as extra beats in generate mode.
//
//   state | meaning
//   RUN   | absorbing data beats, in_ready high
//   EMIT  | driving complemented CRC beats out, input stalled
//   DONE  | one-cycle done pulse, register reinitialised afterwards
module crc_stream
   import crc_pkg::*;
#(
   parameter int               NBITS    = 16,
   parameter int               DW       = 8,
   parameter logic [NBITS-1:0] POLY     = CRC16_POLY,
   parameter logic [NBITS-1:0] RESIDUAL = CRC16_RESIDUAL
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             mode,
   crc_stream_if.slave      bus,
   output logic [NBITS-1:0] crc,
   output logic             done,
   output logic             crc_ok
);

   localparam int              NBEATS = NBITS / DW;
   localparam int              CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CW-1:0]   LAST   = CW'(NBEATS - 1);

   crc_state_t       state, state_next;
   logic [NBITS-1:0] r, r_nxt, r_step;
   logic [NBITS-1:0] s, s_nxt, s_load;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             in_frame, in_frame_nxt;
   logic             mode_q, mode_nxt, mode_eff;
   logic             ok_q, ok_nxt;
   logic             accept;

   crc_step_n #(
      .NBITS (NBITS),
      .DW    (DW),
      .POLY  (POLY)
   ) u_step (
      .r      (r),
      .d      (bus.in_data),
      .r_next (r_step)
   );

   // The wire order is MSB of the register first, one beat's LSB first.
   always_comb begin
      s_load = '0;
      for (int i = 0; i < NBITS; i++) s_load[i] = ~r_step[NBITS-1-i];
   end

   assign bus.in_ready  = (state == RUN) && !clear;
   assign bus.out_valid = (state == EMIT);
   assign bus.out_data  = s[DW-1:0];
   assign bus.out_last  = (state == EMIT) && (cnt == LAST);
   assign accept        = bus.in_valid && bus.in_ready;
   assign mode_eff      = in_frame ? mode_q : mode;
   assign done          = (state == DONE) && !clear;
   assign crc_ok        = ok_q;
   assign crc           = ~r;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= RUN;
         r        <= '1;
         s        <= '0;
         cnt      <= '0;
         in_frame <= 1'b0;
         mode_q   <= 1'b0;
         ok_q     <= 1'b0;
      end else begin
         state    <= state_next;
         r        <= r_nxt;
         s        <= s_nxt;
         cnt      <= cnt_nxt;
         in_frame <= in_frame_nxt;
         mode_q   <= mode_nxt;
         ok_q     <= ok_nxt;
      end
   end

   always_comb begin
      state_next   = state;
      r_nxt        = r;
      s_nxt        = s;
      cnt_nxt      = cnt;
      in_frame_nxt = in_frame;
      mode_nxt     = mode_q;
      ok_nxt       = ok_q;
      if (clear) begin
         state_next   = RUN;
         r_nxt        = '1;
         cnt_nxt      = '0;
         in_frame_nxt = 1'b0;
         ok_nxt       = 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (accept) begin
                  r_nxt        = r_step;
                  mode_nxt     = mode_eff;
                  in_frame_nxt = !bus.in_last;
                  if (bus.in_last) begin
                     if (mode_eff) begin
                        state_next = EMIT;
                        s_nxt      = s_load;
                        cnt_nxt    = '0;
                     end else begin
                        state_next = DONE;
                        ok_nxt     = (r_step == RESIDUAL);
                     end
                  end
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  s_nxt   = s >> DW;
                  cnt_nxt = cnt + CW'(1);
                  if (cnt == LAST) begin
                     state_next = DONE;
                     ok_nxt     = 1'b0;
                  end
               end
            end
            DONE: begin
               state_next = RUN;
               r_nxt      = '1;
            end
            default: state_next = RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: CRC-16/DW=8 and CRC-5/DW=1 instances against a bit-serial model.
module tb_crc_stream;
   import crc_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        clear8, mode8, done8, ok8;
   logic [15:0] crc8;
   logic        clear1, mode1, done1, ok1;
   logic [4:0]  crc1;
   int          tests = 0;
   int          fails = 0;

   logic [8:0]  exp8_q[$];
   logic [1:0]  exp1_q[$];
   logic [7:0]  fr8[$];
   logic [7:0]  gen8[$];
   logic        fr1[$];
   logic        gen1[$];

   crc_stream_if #(.DW(8)) if8();
   crc_stream_if #(.DW(1)) if1();

   crc_stream #(
      .NBITS(16), .DW(8), .POLY(CRC16_POLY), .RESIDUAL(CRC16_RESIDUAL)
   ) dut8 (
      .clk(clk), .n_rst(n_rst), .clear(clear8), .mode(mode8), .bus(if8),
      .crc(crc8), .done(done8), .crc_ok(ok8)
   );

   crc_stream #(
      .NBITS(5), .DW(1), .POLY(CRC5_POLY), .RESIDUAL(CRC5_RESIDUAL)
   ) dut1 (
      .clk(clk), .n_rst(n_rst), .clear(clear1), .mode(mode1), .bus(if1),
      .crc(crc1), .done(done1), .crc_ok(ok1)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] crc16_of(input logic [7:0] d[$]);
      logic [15:0] r = 16'hFFFF;
      foreach (d[k])
         for (int i = 0; i < 8; i++)
            r = (d[k][i] ^ r[15]) ? ({r[14:0], 1'b0} ^ CRC16_POLY) : {r[14:0], 1'b0};
      return r;
   endfunction

   function automatic logic [4:0] crc5_of(input logic d[$]);
      logic [4:0] r = 5'h1F;
      foreach (d[k])
         r = (d[k] ^ r[4]) ? ({r[3:0], 1'b0} ^ CRC5_POLY) : {r[3:0], 1'b0};
      return r;
   endfunction

   function automatic logic [15:0] tx16(input logic [15:0] m);
      logic [15:0] sv;
      for (int i = 0; i < 16; i++) sv[i] = ~m[15-i];
      return sv;
   endfunction

   task automatic send8(input logic [7:0] d, input logic last, input string tag);
      int n = 0;
      if8.in_valid = 1'b1; if8.in_data = d; if8.in_last = last;
      while (!if8.in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL %s_in_timeout: in_ready=%b, want 1", tag, if8.in_ready);
      end
      @(negedge clk);
      if8.in_valid = 1'b0; if8.in_last = 1'b0;
   endtask

   task automatic send1(input logic d, input logic last, input string tag);
      int n = 0;
      if1.in_valid = 1'b1; if1.in_data = d; if1.in_last = last;
      while (!if1.in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL %s_in_timeout: in_ready=%b, want 1", tag, if1.in_ready);
      end
      @(negedge clk);
      if1.in_valid = 1'b0; if1.in_last = 1'b0;
   endtask

   task automatic frame8(input logic [7:0] d[$], input logic gen, input logic exp_ok,
                         input int stall, input string tag);
      logic [15:0] m, sv;
      logic [8:0]  e, first;
      int          n;
      m = crc16_of(d);
      mode8 = gen;
      gen8.delete();
      foreach (d[k]) begin
         if (gen && k == d.size() - 1) begin
            sv = tx16(m);
            exp8_q.push_back({sv[7:0], 1'b0});
            exp8_q.push_back({sv[15:8], 1'b1});
         end
         send8(d[k], k == d.size() - 1, tag);
         mode8 = ~gen;
      end
      if (gen) begin
         tests++;
         if (if8.out_valid !== 1'b1)
            begin fails++; $display("FAIL %s_out_latency: out_valid=%b, want 1", tag, if8.out_valid); end
         first = exp8_q[0];
         repeat (stall) begin
            tests++;
            if ({if8.out_valid, if8.out_data} !== {1'b1, first[8:1]}) begin
               fails++;
               $display("FAIL %s_stall_out: got %b/%h, want 1/%h", tag, if8.out_valid, if8.out_data, first[8:1]);
            end
            tests++;
            if ({if8.in_ready, done8} !== 2'b00)
               begin fails++; $display("FAIL %s_stall_ctl: in_ready/done=%b%b, want 00", tag, if8.in_ready, done8); end
            @(negedge clk);
         end
         if8.out_ready = 1'b1;
         n = 0;
         while (exp8_q.size() > 0 && n < 20) begin
            if (if8.out_valid) begin
               e = exp8_q.pop_front();
               gen8.push_back(if8.out_data);
               tests++;
               if ({if8.out_data, if8.out_last} !== e) begin
                  fails++;
                  $display("FAIL %s_beat: got %h last=%b, want %h last=%b", tag, if8.out_data, if8.out_last, e[8:1], e[0]);
               end
               tests++;
               if (done8 !== 1'b0) begin fails++; $display("FAIL %s_early_done: done=%b, want 0", tag, done8); end
            end
            @(negedge clk); n++;
         end
         if8.out_ready = 1'b0;
         tests++;
         if (exp8_q.size() != 0) begin
            fails++; $display("FAIL %s_out_timeout: %0d beats missing, want 0", tag, exp8_q.size());
            exp8_q.delete();
         end
      end
      tests++;
      if ({done8, ok8} !== {1'b1, exp_ok})
         begin fails++; $display("FAIL %s_done: done/crc_ok=%b%b, want 1%b", tag, done8, ok8, exp_ok); end
      tests++;
      if (crc8 !== ~m) begin fails++; $display("FAIL %s_crc: got %h, want %h", tag, crc8, ~m); end
      @(negedge clk);
      tests++;
      if ({done8, if8.out_valid, if8.in_ready, crc8} !== {3'b001, 16'h0000}) begin
         fails++;
         $display("FAIL %s_idle: done/ov/ir=%b%b%b crc=%h, want 001 0000", tag, done8, if8.out_valid, if8.in_ready, crc8);
      end
   endtask

   task automatic frame1(input logic d[$], input logic gen, input logic exp_ok, input string tag);
      logic [4:0] m;
      logic [1:0] e;
      int         n;
      m = crc5_of(d);
      mode1 = gen;
      gen1.delete();
      foreach (d[k]) begin
         if (gen && k == d.size() - 1)
            for (int i = 0; i < 5; i++) exp1_q.push_back({~m[4-i], i == 4});
         send1(d[k], k == d.size() - 1, tag);
         mode1 = ~gen;
      end
      if (gen) begin
         if1.out_ready = 1'b1;
         n = 0;
         while (exp1_q.size() > 0 && n < 20) begin
            if (if1.out_valid) begin
               e = exp1_q.pop_front();
               gen1.push_back(if1.out_data[0]);
               tests++;
               if ({if1.out_data, if1.out_last} !== e) begin
                  fails++;
                  $display("FAIL %s_beat: got %b last=%b, want %b last=%b", tag, if1.out_data, if1.out_last, e[1], e[0]);
               end
            end
            @(negedge clk); n++;
         end
         if1.out_ready = 1'b0;
         tests++;
         if (exp1_q.size() != 0) begin
            fails++; $display("FAIL %s_out_timeout: %0d beats missing, want 0", tag, exp1_q.size());
            exp1_q.delete();
         end
      end
      tests++;
      if ({done1, ok1, crc1} !== {1'b1, exp_ok, ~m}) begin
         fails++;
         $display("FAIL %s_done: done/ok=%b%b crc=%h, want 1%b crc=%h", tag, done1, ok1, crc1, exp_ok, ~m);
      end
      @(negedge clk);
   endtask

   task automatic make_good8();
      logic [15:0] sv;
      fr8.delete();
      for (int i = 0; i < 4; i++) fr8.push_back(8'(i));
      sv = tx16(crc16_of(fr8));
      fr8.push_back(sv[7:0]);
      fr8.push_back(sv[15:8]);
   endtask

   task automatic test_reset();
      n_rst = 1'b1;
      #1 n_rst = 1'b0;
      #2;
      tests++;
      if ({crc8, done8, ok8, if8.out_valid, if8.out_last} !== 20'h0) begin
         fails++;
         $display("FAIL reset_async: crc=%h d/ok/ov/ol=%b%b%b%b, want 0", crc8, done8, ok8, if8.out_valid, if8.out_last);
      end
      @(negedge clk) n_rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({crc8, if8.in_ready, if8.out_valid, done8, ok8} !== {16'h0000, 4'b1000}) begin
         fails++;
         $display("FAIL reset_idle8: crc=%h ir/ov/d/ok=%b%b%b%b, want 0000 1000", crc8, if8.in_ready, if8.out_valid, done8, ok8);
      end
      tests++;
      if ({crc1, if1.in_ready, if1.out_valid, done1, ok1} !== {5'h00, 4'b1000}) begin
         fails++;
         $display("FAIL reset_idle1: crc=%h ir/ov/d/ok=%b%b%b%b, want 00 1000", crc1, if1.in_ready, if1.out_valid, done1, ok1);
      end
   endtask

   task automatic test_check();
      make_good8();
      frame8(fr8, 1'b0, 1'b1, 0, "chk_good");
      fr8[1] = fr8[1] ^ 8'h04;
      frame8(fr8, 1'b0, 1'b0, 0, "chk_flip");
   endtask

   task automatic test_generate();
      fr8.delete();
      for (int i = 0; i < 4; i++) fr8.push_back(8'(i));
      frame8(fr8, 1'b1, 1'b0, 0, "gen");
      foreach (gen8[k]) fr8.push_back(gen8[k]);
      frame8(fr8, 1'b0, 1'b1, 0, "gen_loop");
   endtask

   task automatic test_clear();
      mode8 = 1'b0;
      send8(8'h00, 1'b0, "clr"); send8(8'h01, 1'b0, "clr"); send8(8'h02, 1'b0, "clr");
      if8.in_valid = 1'b1; if8.in_data = 8'h03; if8.in_last = 1'b1; clear8 = 1'b1;
      #1;
      tests++;
      if (if8.in_ready !== 1'b0) begin fails++; $display("FAIL clr_ready: in_ready=%b, want 0", if8.in_ready); end
      @(negedge clk);
      clear8 = 1'b0; if8.in_valid = 1'b0; if8.in_last = 1'b0;
      tests++;
      if ({done8, ok8, if8.out_valid, crc8} !== 19'h0) begin
         fails++; $display("FAIL clr_last: d/ok/ov=%b%b%b crc=%h, want 000 0000", done8, ok8, if8.out_valid, crc8);
      end
      @(negedge clk);
      tests++;
      if (done8 !== 1'b0) begin fails++; $display("FAIL clr_nodone: done=%b, want 0", done8); end
      make_good8();
      frame8(fr8, 1'b0, 1'b1, 0, "clr_after_last");
      mode8 = 1'b1;
      send8(8'h11, 1'b0, "clr");
      send8(8'h22, 1'b1, "clr");
      tests++;
      if (if8.out_valid !== 1'b1) begin fails++; $display("FAIL clr_emit_entry: out_valid=%b, want 1", if8.out_valid); end
      clear8 = 1'b1;
      @(negedge clk);
      clear8 = 1'b0;
      tests++;
      if ({done8, ok8, if8.out_valid, crc8} !== 19'h0) begin
         fails++; $display("FAIL clr_emit: d/ok/ov=%b%b%b crc=%h, want 000 0000", done8, ok8, if8.out_valid, crc8);
      end
      @(negedge clk);
      tests++;
      if ({done8, if8.in_ready} !== 2'b01) begin
         fails++; $display("FAIL clr_emit_idle: done/in_ready=%b%b, want 01", done8, if8.in_ready);
      end
      fr8.delete();
      for (int i = 0; i < 4; i++) fr8.push_back(8'(i));
      frame8(fr8, 1'b1, 1'b0, 0, "clr_after_emit");
   endtask

   task automatic test_stall();
      fr8.delete();
      fr8.push_back(8'hA5); fr8.push_back(8'h3C); fr8.push_back(8'hFF);
      frame8(fr8, 1'b1, 1'b0, 5, "stall");
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 4; t++) begin
         fr8.delete();
         fr8.push_back(8'($urandom_range(255, 0)));
         if (t % 2 == 1) fr8.push_back(8'($urandom_range(255, 0)));
         frame8(fr8, t[0], !t[0] && (crc16_of(fr8) == CRC16_RESIDUAL), 0, "b2b");
      end
   endtask

   task automatic test_dw1();
      int len;
      for (int t = 0; t < 5; t++) begin
         fr1.delete();
         len = $urandom_range(12, 1);
         repeat (len) fr1.push_back(1'($urandom_range(1, 0)));
         frame1(fr1, 1'b1, 1'b0, "dw1_gen");
         foreach (gen1[k]) fr1.push_back(gen1[k]);
         frame1(fr1, 1'b0, 1'b1, "dw1_loop");
         fr1.delete();
         len = $urandom_range(12, 1);
         repeat (len) fr1.push_back(1'($urandom_range(1, 0)));
         frame1(fr1, 1'b0, crc5_of(fr1) == CRC5_RESIDUAL, "dw1_chk");
      end
   endtask

   initial begin
      clear8 = 1'b0; mode8 = 1'b0; clear1 = 1'b0; mode1 = 1'b0;
      if8.in_valid = 1'b0; if8.in_data = '0; if8.in_last = 1'b0; if8.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
      test_reset();
      test_check();
      test_generate();
      test_clear();
      test_stall();
      test_back_to_back();
      test_dw1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Multi-bit, parametrised streaming CRC engine for the USB packet datapath.
- Absorbs one DW-bit beat per cycle over a valid/ready handshake and detects frame end on in_last.
- Check mode: after the frame, reports whether the register holds the residual.
- Generate mode: after the frame, emits the complemented CRC as extra beats so it can be appended to a transmitted packet.

Parameters:
- NBITS, 16, CRC register width; must be an integer multiple of DW.
- DW, 8, data bits per beat; bit 0 is processed first (LSB-first on the wire).
- POLY, 16'h8005, generator polynomial, implicit x^NBITS term omitted.
- RESIDUAL, 16'h800D, register value indicating a good frame in check mode.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort/reinit, highest priority
- mode  in  1  0 = check, 1 = generate; latched on first accepted beat of a frame
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat this cycle
- in_data  in  DW  input beat
- in_last  in  1  beat is final data beat of frame
- out_valid  out  1  CRC beat available (generate mode only)
- out_ready  in  1  downstream accepts CRC beat
- out_data  out  DW  CRC beat
- out_last  out  1  final CRC beat
- crc  out  NBITS  live ~register
- done  out  1  one-cycle frame-complete pulse
- crc_ok  out  1  check result of last frame, held until next done or clear

Behaviour:
- Reset (n_rst low, async):
  - register all ones, state RUN, in_frame 0, mode_q 0.
  - out_valid 0, out_last 0, done 0, crc_ok 0; crc = 0.
- Per-bit step, applied for bits 0..DW-1 within one cycle (unrolled combinationally):
  - flip = d ^ r[NBITS-1]
  - r = {r[NBITS-2:0],1'b0} ^ (flip ? POLY : 0)
  - Result must equal DW consecutive serial steps.
- States:
  - RUN:
    - in_ready = 1.
    - On each in_valid&&in_ready, update the register.
    - On the first beat of a frame (in_frame 0): set in_frame, latch mode_q = mode.
    - On a beat with in_last: clear in_frame; go to EMIT if mode_q = 1, else DONE.
  - EMIT:
    - in_ready = 0.
    - On entry, load shift register S = ~r bit-reversed, so S[i] = ~r[NBITS-1-i].
    - out_valid = 1, out_data = S[DW-1:0].
    - Beat counter runs 0..NBITS/DW-1; out_last = 1 when the counter is at its final value.
    - On out_valid&&out_ready: S >>= DW and the counter increments.
    - After the handshake on the last beat, go to DONE.
    - out_data holds stable while out_ready is low.
  - DONE (exactly one cycle):
    - done = 1, in_ready = 0.
    - crc_ok = (mode_q = 0) && (r == RESIDUAL); in generate mode crc_ok = 0.
    - crc still shows the final frame value this cycle.
    - Next cycle: register reinitialised to all ones, state RUN.
- Latency:
  - Check mode: done is asserted 1 cycle after the in_last handshake.
  - Generate mode: the first out_valid is asserted 1 cycle after the in_last handshake; done follows 1 cycle after the final out handshake.
- clear:
  - Synchronous and overrides every other event in the same cycle.
  - Effect: register all ones, state RUN, in_frame 0, out_valid 0, no done pulse, crc_ok 0.
  - in_ready = 0 during the clear cycle; a beat offered with clear high is not consumed.
- Mode change mid-frame is ignored; mode is sampled only on the first beat.
- in_valid with in_ready low: beat is not consumed; the source must hold it.
- A single-beat frame (first beat carries in_last) is legal.
- An empty frame is impossible: frames start with a beat.
- Loopback property: generate-mode out beats fed back as trailing beats in check mode must yield crc_ok = 1.

Decomposition:
- Shared package crc_pkg holds:
  - the state enum (RUN, EMIT, DONE);
  - USB constants CRC16_POLY = 16'h8005, CRC16_RESIDUAL = 16'h800D, CRC5_POLY = 5'h05, CRC5_RESIDUAL = 5'h0C.
- One sub-module, crc_step_n: purely combinational (r, d[DW-1:0]) -> r_next, instantiated once.
- The FSM, emit shifter and counter stay in crc_stream.

Test Plan:
- Reset, then idle:
  - crc = 16'h0000, in_ready = 1, out_valid = 0, done = 0, crc_ok = 0.
- Check mode, beats 0x00 0x01 0x02 0x03 (last on 0x03), then two CRC bytes from the bit-serial golden model:
  - done pulses 1 cycle after the final beat, crc_ok = 1.
  - Repeat with one data bit flipped: crc_ok = 0.
- Generate mode, same four beats:
  - exactly 2 out beats, out_last only on the second, bytes equal the golden-model CRC.
  - Loop those bytes back in check mode: crc_ok = 1.
- out_ready held low 5 cycles in EMIT:
  - out_data and out_valid stable, in_ready = 0, no done.
  - Release: completes normally.
- clear asserted together with an in_last handshake, and again mid-EMIT:
  - no done pulse, out_valid drops next cycle, crc = 0, the next frame computes correctly.
- DW = 1, NBITS = 5, POLY = 5'h05, RESIDUAL = 5'h0C:
  - random frames match the bit-serial golden model.
  - Generate-then-check loopback gives crc_ok = 1.
